// File: rtl/quad_encoder_pkg.sv
// Shared constants for the quadrature encoder array:
// step modes, phase codes and parameter range limits.
package quad_encoder_pkg;

  localparam int STEP_X1 = 0;
  localparam int STEP_X2 = 1;
  localparam int STEP_X4 = 2;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;
  localparam int CNT_W_MIN  = 8;
  localparam int CNT_W_MAX  = 32;
  localparam int DEB_MIN    = 1;
  localparam int DEB_MAX    = 65535;
  localparam int DEB_W      = 16;

  // Direction is decided elsewhere; this only asks whether the
  // phase just entered is a counting point for the resolution.
  function automatic logic step_counts(
    input int         mode,
    input logic [1:0] ph
  );
    logic r;
    r = 1'b1;
    if (mode == STEP_X2)
      r = (ph == PH_00) || (ph == PH_11);
    else if (mode == STEP_X1)
      r = (ph == PH_00);
    return r;
  endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One encoder channel: synchroniser, debouncer, decoder, counter.
// Optional sticky err output under QUAD_ENCODER_ERR_DETECT_EN.
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEB_CYCLES  = 50,
  parameter int ACTIVE_HIGH = 1,
  parameter int STEP_MODE   = STEP_X4,
  parameter int SATURATE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic             cw_pulse,
  output logic             ccw_pulse,
  output logic [CNT_W-1:0] position
`ifdef QUAD_ENCODER_ERR_DETECT_EN
  ,
  output logic             err
`endif
);

  localparam logic [CNT_W-1:0] POS_MAX =
    {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] POS_MIN =
    {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [DEB_W-1:0] DEB_LIM = DEB_W'(DEB_CYCLES);

  logic [1:0]       raw;
  logic [1:0]       s1_q, s2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       prev_q;
  logic [DEB_W-1:0] cnt_q [2];
  logic [DEB_W-1:0] cnt_d [2];
  logic             mv_cw, mv_ccw;
  logic             cw_d, cw_q, ccw_d, ccw_q;
  logic [CNT_W-1:0] pos_d, pos_q;

  assign raw = (ACTIVE_HIGH != 0) ? {a_in, b_in}
                                  : ~{a_in, b_in};

  // The count must reach the limit and still see a difference,
  // so the bit flips one edge after DEB_CYCLES stable cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LIM)
          deb_d[i] = s2_q[i];
        else
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
    end
  end

  always_comb begin
    mv_cw  = 1'b0;
    mv_ccw = 1'b0;
    unique case ({prev_q, deb_q})
      {PH_00, PH_01}, {PH_01, PH_11},
      {PH_11, PH_10}, {PH_10, PH_00}: mv_cw = 1'b1;
      {PH_00, PH_10}, {PH_10, PH_11},
      {PH_11, PH_01}, {PH_01, PH_00}: mv_ccw = 1'b1;
      default: ;
    endcase
  end

  assign cw_d  = enable & mv_cw &
                 step_counts(STEP_MODE, deb_q);
  assign ccw_d = enable & mv_ccw &
                 step_counts(STEP_MODE, deb_q);

  always_comb begin
    pos_d = pos_q;
    if (cw_d)
      pos_d = (SATURATE != 0 && pos_q == POS_MAX)
              ? pos_q : pos_q + CNT_W'(1);
    else if (ccw_d)
      pos_d = (SATURATE != 0 && pos_q == POS_MIN)
              ? pos_q : pos_q - CNT_W'(1);
    if (clear)
      pos_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      prev_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      cw_q     <= 1'b0;
      ccw_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      prev_q   <= deb_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      cw_q     <= cw_d;
      ccw_q    <= ccw_d;
      pos_q    <= pos_d;
    end
  end

  assign cw_pulse  = cw_q;
  assign ccw_pulse = ccw_q;
  assign position  = pos_q;

`ifdef QUAD_ENCODER_ERR_DETECT_EN
  logic bad;
  logic err_d, err_q;

  assign bad = ((prev_q ^ deb_q) == 2'b11);

  always_comb begin
    err_d = err_q;
    if (clear)
      err_d = 1'b0;
    if (bad)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: rtl/quad_encoder_array.sv
// NUM_CH independent quadrature encoder channels.
// Define QUAD_ENCODER_ERR_DETECT_EN to add the sticky err output.
module quad_encoder_array
  import quad_encoder_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEB_CYCLES  = 50,
  parameter int ACTIVE_HIGH = 1,
  parameter int STEP_MODE   = STEP_X4,
  parameter int SATURATE    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       a_in,
  input  logic [NUM_CH-1:0]       b_in,
  input  logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH-1:0]       cw_pulse,
  output logic [NUM_CH-1:0]       ccw_pulse,
  output logic [NUM_CH*CNT_W-1:0] position
`ifdef QUAD_ENCODER_ERR_DETECT_EN
  ,
  output logic [NUM_CH-1:0]       err
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    quad_encoder_channel #(
      .CNT_W      (CNT_W),
      .DEB_CYCLES (DEB_CYCLES),
      .ACTIVE_HIGH(ACTIVE_HIGH),
      .STEP_MODE  (STEP_MODE),
      .SATURATE   (SATURATE)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .a_in     (a_in[g]),
      .b_in     (b_in[g]),
      .clear    (clear[g]),
      .cw_pulse (cw_pulse[g]),
      .ccw_pulse(ccw_pulse[g]),
      .position (position[g*CNT_W +: CNT_W])
`ifdef QUAD_ENCODER_ERR_DETECT_EN
      ,
      .err      (err[g])
`endif
    );
  end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Bench for quad_encoder_array: six configurations share stimulus
// and are compared against an angle-based reference model.
module tb_quad_encoder_array;

  localparam int ND  = 6;
  localparam int NC  = 2;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [NC-1:0] a = '0, b = '0, clr = '0;
  logic [NC-1:0] cwv [ND];
  logic [NC-1:0] ccwv [ND];
  logic [2*16-1:0] pv16 [4];
  logic [2*8-1:0]  pv8 [2];
`ifdef QUAD_ENCODER_ERR_DETECT_EN
  logic [NC-1:0] errv [ND];
`endif

  // d0 x4, d1 x2, d2 x1, d3 x4 inverted, d4 8b wrap, d5 8b sat
  int mode [ND] = '{2, 1, 0, 2, 2, 2};
  int wid  [ND] = '{16, 16, 16, 16, 8, 8};
  int sat  [ND] = '{0, 0, 0, 0, 0, 1};

  int vecs = 0;
  int errs = 0;
  logic [1:0] ph [NC];
  int epos [ND][NC];
  int ecw  [ND][NC];
  int eccw [ND][NC];
  int ocw  [ND][NC];
  int occw [ND][NC];
  bit eerr [NC];

  always #5 clk = ~clk;

`define QE_ERR(i) \
  `ifdef QUAD_ENCODER_ERR_DETECT_EN , .err(errv[i]) `endif

  quad_encoder_array #(.NUM_CH(NC), .CNT_W(16),
    .DEB_CYCLES(DEB), .ACTIVE_HIGH(1), .STEP_MODE(2),
    .SATURATE(0)) u_x4 (
    .clk(clk), .reset(reset), .enable(enable),
    .a_in(a), .b_in(b), .clear(clr),
    .cw_pulse(cwv[0]), .ccw_pulse(ccwv[0]),
    .position(pv16[0]) `QE_ERR(0));

  quad_encoder_array #(.NUM_CH(NC), .CNT_W(16),
    .DEB_CYCLES(DEB), .ACTIVE_HIGH(1), .STEP_MODE(1),
    .SATURATE(0)) u_x2 (
    .clk(clk), .reset(reset), .enable(enable),
    .a_in(a), .b_in(b), .clear(clr),
    .cw_pulse(cwv[1]), .ccw_pulse(ccwv[1]),
    .position(pv16[1]) `QE_ERR(1));

  quad_encoder_array #(.NUM_CH(NC), .CNT_W(16),
    .DEB_CYCLES(DEB), .ACTIVE_HIGH(1), .STEP_MODE(0),
    .SATURATE(0)) u_x1 (
    .clk(clk), .reset(reset), .enable(enable),
    .a_in(a), .b_in(b), .clear(clr),
    .cw_pulse(cwv[2]), .ccw_pulse(ccwv[2]),
    .position(pv16[2]) `QE_ERR(2));

  quad_encoder_array #(.NUM_CH(NC), .CNT_W(16),
    .DEB_CYCLES(DEB), .ACTIVE_HIGH(0), .STEP_MODE(2),
    .SATURATE(0)) u_inv (
    .clk(clk), .reset(reset), .enable(enable),
    .a_in(~a), .b_in(~b), .clear(clr),
    .cw_pulse(cwv[3]), .ccw_pulse(ccwv[3]),
    .position(pv16[3]) `QE_ERR(3));

  quad_encoder_array #(.NUM_CH(NC), .CNT_W(8),
    .DEB_CYCLES(DEB), .ACTIVE_HIGH(1), .STEP_MODE(2),
    .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable),
    .a_in(a), .b_in(b), .clear(clr),
    .cw_pulse(cwv[4]), .ccw_pulse(ccwv[4]),
    .position(pv8[0]) `QE_ERR(4));

  quad_encoder_array #(.NUM_CH(NC), .CNT_W(8),
    .DEB_CYCLES(DEB), .ACTIVE_HIGH(1), .STEP_MODE(2),
    .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable),
    .a_in(a), .b_in(b), .clear(clr),
    .cw_pulse(cwv[5]), .ccw_pulse(ccwv[5]),
    .position(pv8[1]) `QE_ERR(5));

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < NC; c++) begin
        if (cwv[d][c] === 1'b1)
          ocw[d][c] <= ocw[d][c] + 1;
        if (ccwv[d][c] === 1'b1)
          occw[d][c] <= occw[d][c] + 1;
      end
  end

  function automatic int pos(int d, int c);
    if (d < 4)
      return int'($signed(pv16[d][c*16 +: 16]));
    return int'($signed(pv8[d-4][c*8 +: 8]));
  endfunction

  function automatic logic [31:0] praw(int d);
    if (d < 4)
      return {16'h0, pv16[d]};
    return {16'h0, pv8[d-4]};
  endfunction

  // Quarter-turn angle of a phase along the CW sequence.
  function automatic int ang(logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] nxt_cw(logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int bump(int d, int v);
    int mx, mn;
    mx = (1 << (wid[d] - 1)) - 1;
    mn = -(1 << (wid[d] - 1));
    if (v > mx) return (sat[d] != 0) ? mx : mn;
    if (v < mn) return (sat[d] != 0) ? mn : mx;
    return v;
  endfunction

  task automatic model_step(int c, logic [1:0] np, bit cl);
    int dir;
    bit hit;
    dir = (ang(np) - ang(ph[c]) + 4) % 4;
    for (int d = 0; d < ND; d++) begin
      hit = 1'b0;
      if (enable && (dir == 1 || dir == 3)) begin
        if (mode[d] == 2)      hit = 1'b1;
        else if (mode[d] == 1) hit = (np == 2'b00 || np == 2'b11);
        else                   hit = (np == 2'b00);
      end
      if (hit && dir == 1) begin
        ecw[d][c]++;
        epos[d][c] = bump(d, epos[d][c] + 1);
      end
      if (hit && dir == 3) begin
        eccw[d][c]++;
        epos[d][c] = bump(d, epos[d][c] - 1);
      end
      if (cl) epos[d][c] = 0;
    end
    if (cl) eerr[c] = 1'b0;
    if (dir == 2) eerr[c] = 1'b1;
    ph[c] = np;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      ph[c] = 2'b00;
      eerr[c] = 1'b0;
      for (int d = 0; d < ND; d++) epos[d][c] = 0;
    end
  endtask

  task automatic drive(int c, logic [1:0] p);
    a[c] = p[1];
    b[c] = p[0];
  endtask

  task automatic seg(logic [1:0] n0, logic [1:0] n1, int hold);
    drive(0, n0);
    drive(1, n1);
    repeat (hold) @(negedge clk);
    model_step(0, n0, 1'b0);
    model_step(1, n1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a = '0; b = '0; clr = '0; enable = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      vecs++;
      if (praw(d) !== 32'h0 || cwv[d] !== '0 ||
          ccwv[d] !== '0) begin
        errs++;
        $display("FAIL reset d%0d pos=%h cw=%b ccw=%b exp 0",
                 d, praw(d), cwv[d], ccwv[d]);
      end
`ifdef QUAD_ENCODER_ERR_DETECT_EN
      vecs++;
      if (errv[d] !== '0) begin
        errs++;
        $display("FAIL reset_err d%0d got %b exp 00", d, errv[d]);
      end
`endif
    end
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_cycles();
    logic [1:0] sq [2][4];
    sq = '{'{2'b01, 2'b11, 2'b10, 2'b00},
           '{2'b10, 2'b11, 2'b01, 2'b00}};
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 4; s++) seg(sq[p][s], ph[1], 10);
      for (int d = 0; d < ND; d++) begin
        vecs++;
        if (pos(d, 0) != epos[d][0] || ocw[d][0] != ecw[d][0] ||
            occw[d][0] != eccw[d][0]) begin
          errs++;
          $display("FAIL cycle%0d d%0d pos=%0d cw=%0d ccw=%0d exp %0d %0d %0d",
                   p, d, pos(d, 0), ocw[d][0], occw[d][0],
                   epos[d][0], ecw[d][0], eccw[d][0]);
        end
      end
    end
  endtask

  task automatic test_glitch_latency();
    int n;
    logic [1:0] np;
    for (int g = 0; g < 3; g++) begin
      a[0] = ~a[0];
      @(negedge clk);
      a[0] = ~a[0];
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      vecs++;
      if (pos(d, 0) != epos[d][0] || ocw[d][0] != ecw[d][0] ||
          occw[d][0] != eccw[d][0]) begin
        errs++;
        $display("FAIL glitch d%0d pos=%0d cw=%0d ccw=%0d exp %0d %0d %0d",
                 d, pos(d, 0), ocw[d][0], occw[d][0],
                 epos[d][0], ecw[d][0], eccw[d][0]);
      end
    end
    np = nxt_cw(ph[0]);
    drive(0, np);
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (cwv[0][0] !== 1'b1 && n < 20);
    vecs++;
    if (n != DEB + 3) begin
      errs++;
      $display("FAIL latency got %0d edges exp %0d", n, DEB + 3);
    end
    @(negedge clk);
    repeat (3) @(negedge clk);
    model_step(0, np, 1'b0);
    vecs++;
    if (pos(0, 0) != epos[0][0]) begin
      errs++;
      $display("FAIL latency_pos got %0d exp %0d",
               pos(0, 0), epos[0][0]);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (p == 1) begin
        enable = 1'b1;
        repeat (10) @(negedge clk);
      end else begin
        seg(nxt_cw(ph[0]), ph[1], 10);
        if (p == 0) seg(nxt_cw(ph[0]), ph[1], 10);
      end
      for (int d = 0; d < ND; d++) begin
        vecs++;
        if (pos(d, 0) != epos[d][0] || ocw[d][0] != ecw[d][0] ||
            occw[d][0] != eccw[d][0]) begin
          errs++;
          $display("FAIL enable%0d d%0d pos=%0d cw=%0d ccw=%0d exp %0d %0d %0d",
                   p, d, pos(d, 0), ocw[d][0], occw[d][0],
                   epos[d][0], ecw[d][0], eccw[d][0]);
        end
      end
    end
  endtask

  task automatic test_clear_step();
    logic [1:0] np;
    np = nxt_cw(ph[0]);
    drive(0, np);
    repeat (7) @(posedge clk);
    #1 clr = 2'b01;
    @(posedge clk);
    #1;
    vecs++;
    if (cwv[0][0] !== 1'b1) begin
      errs++;
      $display("FAIL clear_pulse got %b exp 1", cwv[0][0]);
    end
    vecs++;
    if (pv16[0][15:0] !== 16'h0) begin
      errs++;
      $display("FAIL clear_pos got %h exp 0000", pv16[0][15:0]);
    end
    clr = '0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    model_step(0, np, 1'b1);
    for (int d = 0; d < ND; d++) begin
      vecs++;
      if (pos(d, 0) != epos[d][0] || ocw[d][0] != ecw[d][0]) begin
        errs++;
        $display("FAIL clear d%0d pos=%0d cw=%0d exp %0d %0d",
                 d, pos(d, 0), ocw[d][0], epos[d][0], ecw[d][0]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] n0, n1;
    for (int i = 0; i < 30; i++) begin
      enable = ($urandom_range(0, 4) != 0);
      n0 = 2'($urandom_range(0, 3));
      n1 = 2'($urandom_range(0, 3));
      seg(n0, n1, $urandom_range(10, 14));
      for (int d = 0; d < ND; d++)
        for (int c = 0; c < NC; c++) begin
          vecs++;
          if (pos(d, c) != epos[d][c] || ocw[d][c] != ecw[d][c] ||
              occw[d][c] != eccw[d][c]) begin
            errs++;
            $display("FAIL rand%0d d%0d ch%0d pos=%0d cw=%0d ccw=%0d exp %0d %0d %0d",
                     i, d, c, pos(d, c), ocw[d][c], occw[d][c],
                     epos[d][c], ecw[d][c], eccw[d][c]);
          end
`ifdef QUAD_ENCODER_ERR_DETECT_EN
          vecs++;
          if (errv[d][c] !== eerr[c]) begin
            errs++;
            $display("FAIL rand_err%0d d%0d ch%0d got %b exp %b",
                     i, d, c, errv[d][c], eerr[c]);
          end
`endif
        end
    end
    enable = 1'b1;
  endtask

`ifdef QUAD_ENCODER_ERR_DETECT_EN
  task automatic test_err();
    seg(ph[0], 2'b00, 10);
    clr = 2'b10;
    @(negedge clk);
    clr = '0;
    for (int d = 0; d < ND; d++) epos[d][1] = 0;
    eerr[1] = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (errv[0][1] !== 1'b0) begin
      errs++;
      $display("FAIL err_clear got %b exp 0", errv[0][1]);
    end
    seg(ph[0], 2'b11, 10);
    for (int d = 0; d < ND; d++) begin
      vecs++;
      if (errv[d][1] !== 1'b1 || pos(d, 1) != epos[d][1] ||
          ocw[d][1] != ecw[d][1] || occw[d][1] != eccw[d][1]) begin
        errs++;
        $display("FAIL err_set d%0d err=%b pos=%0d exp 1 %0d",
                 d, errv[d][1], pos(d, 1), epos[d][1]);
      end
    end
  endtask
`endif

  task automatic test_saturate();
    clr = 2'b01;
    @(negedge clk);
    clr = '0;
    for (int d = 0; d < ND; d++) epos[d][0] = 0;
    eerr[0] = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 128; s++) begin
      seg(nxt_cw(ph[0]), ph[1], 10);
      if (s >= 126) begin
        for (int d = 0; d < ND; d++) begin
          vecs++;
          if (pos(d, 0) != epos[d][0]) begin
            errs++;
            $display("FAIL sat_step%0d d%0d got %0d exp %0d",
                     s + 1, d, pos(d, 0), epos[d][0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, nxt_cw(ph[0]));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      vecs++;
      if (praw(d) !== 32'h0 || cwv[d] !== '0 ||
          ccwv[d] !== '0) begin
        errs++;
        $display("FAIL reset_mid d%0d pos=%h cw=%b ccw=%b exp 0",
                 d, praw(d), cwv[d], ccwv[d]);
      end
    end
    reset = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < NC; c++) begin
        vecs++;
        if (pos(d, c) != 0 || ocw[d][c] != ecw[d][c] ||
            occw[d][c] != eccw[d][c]) begin
          errs++;
          $display("FAIL post_reset d%0d ch%0d pos=%0d cw=%0d exp 0 %0d",
                   d, c, pos(d, c), ocw[d][c], ecw[d][c]);
        end
      end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_cycles();
    test_glitch_latency();
    test_enable();
    test_clear_step();
    test_random();
`ifdef QUAD_ENCODER_ERR_DETECT_EN
    test_err();
`endif
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
